// File: rtl/ecc_spi_pkg.sv
// Shared constants and state encodings for the ECC accelerator SPI host.
package ecc_spi_pkg;

  localparam logic [7:0] X_BASE   = 8'h10;
  localparam logic [7:0] Y_BASE   = 8'h20;
  localparam logic [7:0] GO       = 8'hFF;
  localparam logic [7:0] RDX_BASE = 8'h80;
  localparam logic [7:0] RDY_BASE = 8'h90;
  localparam logic [7:0] STATUS   = 8'hF0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_X, ST_WR_Y, ST_WR_GO, ST_ARM, ST_WAIT_HI,
    ST_RD_X, ST_RD_Y, ST_RELEASE, ST_WAIT_LO, ST_FINISH
  } job_state_e;

  typedef enum logic [1:0] {BM_IDLE, BM_SHIFT, BM_GAP} bm_state_e;

  function automatic logic [7:0] byte_addr(input logic [7:0] base, input logic [3:0] idx);
    return base + {4'b0000, idx};
  endfunction

endpackage

// File: rtl/ecc_spi_byte_master.sv
// One 16-bit SPI mode-0 frame (address byte then data byte) per request.
// ack pulses once the last MISO bit is captured, ahead of the CS_GAP tail.
module ecc_spi_byte_master
  import ecc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       rd_i,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  input  logic       spi_miso_i
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  bm_state_e   state_q;
  logic [7:0]  cnt_q;
  logic [5:0]  phase_q;
  logic [15:0] tx_q;
  logic [7:0]  rx_q;
  logic        sclk_q, mosi_q, cs_n_q, ack_q;
  logic        launch_d;

  // A held request launches straight out of the gap so frames run back to back.
  assign launch_d = req_i && ((state_q == BM_IDLE) ||
                              (state_q == BM_GAP && cnt_q == GAP_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BM_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        BM_SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (phase_q == 6'd32) begin
              cs_n_q  <= 1'b1;
              state_q <= BM_GAP;
            end else begin
              phase_q <= phase_q + 6'd1;
              if (!phase_q[0]) begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[6:0], spi_miso_i};
              end else begin
                sclk_q <= 1'b0;
                if (phase_q == 6'd31) begin
                  mosi_q <= 1'b0;
                  ack_q  <= 1'b1;
                end else begin
                  mosi_q <= tx_q[14];
                  tx_q   <= {tx_q[14:0], 1'b0};
                end
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        BM_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= BM_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
      if (launch_d) begin
        state_q <= BM_SHIFT;
        cs_n_q  <= 1'b0;
        sclk_q  <= 1'b0;
        cnt_q   <= '0;
        phase_q <= '0;
        tx_q    <= {addr_i, rd_i ? 8'h00 : wdata_i};
        mosi_q  <= addr_i[7];
      end
    end
  end

  assign ack_o      = ack_q;
  assign rdata_o    = rx_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;

endmodule

// File: rtl/ecc_spi_host.sv
// Job sequencer: loads X/Y into the ECC target over SPI, runs it via the GPIO
// handshake, then reads both result words back.
module ecc_spi_host
  import ecc_spi_pkg::*;
#(
  parameter int          CLK_DIV = 4,
  parameter int          CS_GAP  = 4,
  parameter int unsigned TIMEOUT = 16777216
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] point_x,
  input  logic [127:0] point_y,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result_x,
  output logic [127:0] result_y,
  output logic         spi_sclk,
  output logic         spi_mosi,
  output logic         spi_cs_n,
  input  logic         spi_miso,
  output logic         enable_gpio,
  input  logic         done_gpio
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  job_state_e   state_q;
  logic         busy_q, done_q, error_q, en_q;
  logic         req_q, rd_q;
  logic [7:0]   addr_q, wdata_q;
  logic [3:0]   idx_q, idx_d;
  logic [31:0]  wait_q;
  logic [127:0] px_q, py_q, rx_q, ry_q;
  logic [1:0]   gsync_q;
  logic         gpio_s;
  logic         bm_ack;
  logic [7:0]   bm_rdata;

  assign idx_d  = idx_q + 4'd1;
  assign gpio_s = gsync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gsync_q <= 2'b00;
    else        gsync_q <= {gsync_q[0], done_gpio};
  end

  ecc_spi_byte_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_bm (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_q),
    .addr_i     (addr_q),
    .wdata_i    (wdata_q),
    .rd_i       (rd_q),
    .ack_o      (bm_ack),
    .rdata_o    (bm_rdata),
    .spi_sclk_o (spi_sclk),
    .spi_mosi_o (spi_mosi),
    .spi_cs_n_o (spi_cs_n),
    .spi_miso_i (spi_miso)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
      req_q   <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          busy_q  <= 1'b1;
          error_q <= 1'b0;
          px_q    <= point_x;
          py_q    <= point_y;
          idx_q   <= '0;
          req_q   <= 1'b1;
          rd_q    <= 1'b0;
          addr_q  <= X_BASE;
          wdata_q <= point_x[7:0];
          state_q <= ST_WR_X;
        end
        ST_WR_X: if (bm_ack) begin
          if (idx_q == 4'd15) begin
            idx_q   <= '0;
            addr_q  <= Y_BASE;
            wdata_q <= py_q[7:0];
            state_q <= ST_WR_Y;
          end else begin
            idx_q   <= idx_d;
            addr_q  <= byte_addr(X_BASE, idx_d);
            wdata_q <= px_q[8*idx_d +: 8];
          end
        end
        ST_WR_Y: if (bm_ack) begin
          if (idx_q == 4'd15) begin
            idx_q   <= '0;
            addr_q  <= GO;
            wdata_q <= 8'h00;
            state_q <= ST_WR_GO;
          end else begin
            idx_q   <= idx_d;
            addr_q  <= byte_addr(Y_BASE, idx_d);
            wdata_q <= py_q[8*idx_d +: 8];
          end
        end
        ST_WR_GO: if (bm_ack) begin
          req_q   <= 1'b0;
          state_q <= ST_ARM;
        end
        ST_ARM: begin
          en_q    <= 1'b1;
          wait_q  <= '0;
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (gpio_s) begin
            req_q   <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= RDX_BASE;
            wdata_q <= 8'h00;
            idx_q   <= '0;
            state_q <= ST_RD_X;
          end else if (wait_q == TO_LAST) begin
            error_q <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        // Result bytes land only on ack, i.e. after a whole byte was clocked in.
        ST_RD_X: if (bm_ack) begin
          rx_q[8*idx_q +: 8] <= bm_rdata;
          if (idx_q == 4'd15) begin
            idx_q   <= '0;
            addr_q  <= RDY_BASE;
            state_q <= ST_RD_Y;
          end else begin
            idx_q  <= idx_d;
            addr_q <= byte_addr(RDX_BASE, idx_d);
          end
        end
        ST_RD_Y: if (bm_ack) begin
          ry_q[8*idx_q +: 8] <= bm_rdata;
          if (idx_q == 4'd15) begin
            idx_q   <= '0;
            req_q   <= 1'b0;
            rd_q    <= 1'b0;
            state_q <= ST_RELEASE;
          end else begin
            idx_q  <= idx_d;
            addr_q <= byte_addr(RDY_BASE, idx_d);
          end
        end
        ST_RELEASE: begin
          en_q    <= 1'b0;
          wait_q  <= '0;
          state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!gpio_s) begin
            state_q <= ST_FINISH;
          end else if (wait_q == TO_LAST) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign result_x    = rx_q;
  assign result_y    = ry_q;
  assign enable_gpio = en_q;

endmodule

// File: tb/tb_ecc_spi_host.sv
// Bench: ecc_spi_host against a behavioural SPI slave and ECC target model.
module tb_ecc_spi_host;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 2;
  localparam int TIMEOUT = 1000;
  localparam int TXN_CYC = 33*CLK_DIV + CS_GAP;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [127:0] point_x = '0, point_y = '0;
  logic         busy, done, error, spi_sclk, spi_mosi, spi_cs_n, enable_gpio;
  logic [127:0] result_x, result_y;
  logic         spi_miso = 1'b0, done_gpio = 1'b0;

  ecc_spi_host #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .point_x(point_x), .point_y(point_y),
    .busy(busy), .done(done), .error(error), .result_x(result_x), .result_y(result_y),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .enable_gpio(enable_gpio), .done_gpio(done_gpio)
  );

  always #10 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, n_done = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) n_done <= n_done + 1;

  typedef struct { logic [7:0] a; logic [7:0] d; int t0; int low; } txn_t;
  txn_t       log_q[$];
  logic [7:0] mem [256];
  logic [15:0] sh = '0;
  logic [7:0]  cur_a = '0;
  int          nb = 0, t_fall = 0;
  logic        cs_p = 1'b1, sk_p = 1'b0;
  logic        hang = 1'b0;
  int          en_cnt = 0;

  // SPI slave: sees the bus between clk edges and answers reads MSB first.
  always @(negedge clk) begin
    cs_p <= spi_cs_n;
    sk_p <= spi_sclk;
    if (cs_p && !spi_cs_n) begin
      sh <= '0; nb <= 0; t_fall <= cyc; spi_miso <= 1'b0;
    end else if (!spi_cs_n && !sk_p && spi_sclk) begin
      sh <= {sh[14:0], spi_mosi};
      nb <= nb + 1;
      if (nb == 7) cur_a <= {sh[6:0], spi_mosi};
    end else if (!spi_cs_n && sk_p && !spi_sclk && nb >= 8 && nb < 16) begin
      if (cur_a[7]) spi_miso <= mem[cur_a][15-nb];
    end
    if (!cs_p && spi_cs_n && nb == 16)
      log_q.push_back(txn_t'{sh[15:8], sh[7:0], t_fall, cyc - t_fall});
  end

  // ECC target: completes 100 cycles after enable unless told to hang.
  always @(posedge clk) begin
    if (!enable_gpio) begin
      en_cnt <= 0; done_gpio <= 1'b0;
    end else if (en_cnt < 100) begin
      en_cnt <= en_cnt + 1;
    end else if (!hang) begin
      done_gpio <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int at);
    int k = 0;
    while (!done && k < lim) begin @(negedge clk); k++; end
    at = cyc;
    chk("done_seen", done, 1'b1);
  endtask

  task automatic load_results(input logic [127:0] rx, input logic [127:0] ry);
    for (int i = 0; i < 16; i++) begin
      mem[128+i] = rx[8*i +: 8];
      mem[144+i] = ry[8*i +: 8];
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected frame list: 16 X writes, 16 Y writes, GO, 16 X reads, 16 Y reads.
  task automatic check_job(input string tag, input logic [127:0] px, input logic [127:0] py);
    logic [7:0] ea, ed;
    chk({tag, "_count"}, 128'(log_q.size()), 128'd65);
    if (log_q.size() == 65) begin
      for (int k = 0; k < 65; k++) begin
        if (k < 16)       begin ea = 8'(16 + k);      ed = px[8*k +: 8]; end
        else if (k < 32)  begin ea = 8'(32 + k - 16); ed = py[8*(k-16) +: 8]; end
        else if (k == 32) begin ea = 8'hFF;           ed = 8'h00; end
        else if (k < 49)  begin ea = 8'(128 + k - 33); ed = 8'h00; end
        else              begin ea = 8'(144 + k - 49); ed = 8'h00; end
        chk($sformatf("%s_addr%0d", tag, k), log_q[k].a, ea);
        chk($sformatf("%s_data%0d", tag, k), log_q[k].d, ed);
        chk($sformatf("%s_low%0d", tag, k), 128'(log_q[k].low), 128'(33*CLK_DIV));
        if (k != 0 && k != 33)
          chk($sformatf("%s_period%0d", tag, k), 128'(log_q[k].t0 - log_q[k-1].t0), 128'(TXN_CYC));
      end
    end
  endtask

  initial begin
    logic [127:0] px, py, rx, ry, prev_x, prev_y;
    int t_d, t_en, k, d0, cs_low;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    tick(3);
    chk("rst_busy", busy, 1'b0);   chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0); chk("rst_cs_n", spi_cs_n, 1'b1);
    chk("rst_sclk", spi_sclk, 1'b0); chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_en", enable_gpio, 1'b0);
    chk("rst_rx", result_x, 128'd0); chk("rst_ry", result_y, 128'd0);
    rst_n = 1'b1;
    tick(2);

    // Job 1: directed points, fixed results
    px = 128'h000102030405060708090A0B0C0D0E0F;
    py = 128'h101112131415161718191A1B1C1D1E1F;
    rx = {4{32'hDEADBEEF}};
    ry = ~rx;
    load_results(rx, ry);
    point_x = px; point_y = py;
    log_q.delete();
    pulse_start();
    chk("j1_busy_rise", busy, 1'b1);
    chk("j1_cs_still_high", spi_cs_n, 1'b1);
    point_x = '1; point_y = '1;
    tick(1);
    chk("j1_cs_fall", spi_cs_n, 1'b0);
    wait_done(8000, t_d);
    chk("j1_en_low_at_done", enable_gpio, 1'b0);
    chk("j1_busy_low", busy, 1'b0);
    chk("j1_error", error, 1'b0);
    chk("j1_result_x", result_x, rx);
    chk("j1_result_y", result_y, ry);
    tick(5);
    check_job("j1", px, py);

    // Job 2: random data, extra start pulses while busy
    px = rnd128(); py = rnd128(); rx = rnd128(); ry = rnd128();
    load_results(rx, ry);
    point_x = px; point_y = py;
    log_q.delete();
    d0 = n_done;
    pulse_start();
    for (int p = 0; p < 5; p++) begin
      tick($urandom_range(100, 650));
      point_x = rnd128(); point_y = rnd128();
      pulse_start();
    end
    wait_done(8000, t_d);
    chk("j2_result_x", result_x, rx);
    chk("j2_result_y", result_y, ry);
    tick(5);
    check_job("j2", px, py);
    chk("j2_single_done", 128'(n_done - d0), 128'd1);
    prev_x = rx; prev_y = ry;

    // Timeout: target never completes
    hang = 1'b1;
    point_x = rnd128(); point_y = rnd128();
    log_q.delete();
    pulse_start();
    k = 0;
    while (!enable_gpio && k < 6000) begin @(negedge clk); k++; end
    chk("to_enable_rise", enable_gpio, 1'b1);
    t_en = cyc;
    wait_done(3000, t_d);
    chk("to_latency", ((t_d - t_en) >= TIMEOUT - 2) && ((t_d - t_en) <= TIMEOUT + 2), 1'b1);
    chk("to_error", error, 1'b1);
    chk("to_enable_low", enable_gpio, 1'b0);
    chk("to_busy_low", busy, 1'b0);
    chk("to_rx_held", result_x, prev_x);
    chk("to_ry_held", result_y, prev_y);
    chk("to_writes_only", 128'(log_q.size()), 128'd33);
    tick(10);
    chk("to_error_sticky", error, 1'b1);

    // Next start clears the error and runs a normal job
    hang = 1'b0;
    px = rnd128(); py = rnd128(); rx = rnd128(); ry = rnd128();
    load_results(rx, ry);
    point_x = px; point_y = py;
    log_q.delete();
    pulse_start();
    chk("j4_error_cleared", error, 1'b0);
    wait_done(8000, t_d);
    chk("j4_error", error, 1'b0);
    chk("j4_result_x", result_x, rx);
    chk("j4_result_y", result_y, ry);
    tick(5);
    check_job("j4", px, py);

    // Reset in the middle of an RD_X byte
    log_q.delete();
    pulse_start();
    k = 0;
    while (log_q.size() < 34 && k < 8000) begin @(negedge clk); #1; k++; end
    chk("mr_reached_rdx", log_q.size() >= 34, 1'b1);
    k = 0;
    while (!(nb == 4 && spi_sclk) && k < 500) begin @(negedge clk); #1; k++; end
    chk("mr_mid_byte", spi_cs_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_cs_n", spi_cs_n, 1'b1);   chk("mr_sclk", spi_sclk, 1'b0);
    chk("mr_en", enable_gpio, 1'b0);  chk("mr_mosi", spi_mosi, 1'b0);
    chk("mr_busy", busy, 1'b0);       chk("mr_done", done, 1'b0);
    chk("mr_error", error, 1'b0);
    chk("mr_rx", result_x, 128'd0);   chk("mr_ry", result_y, 128'd0);
    tick(3);
    rst_n = 1'b1;
    cs_low = 0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (!spi_cs_n) cs_low++; end
    chk("mr_no_resume", 128'(cs_low), 128'd0);
    chk("mr_idle_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
